cms_trace_pkt_decoder: RTL and testbench
========================================

// Module: cms_trace_pkt_decoder
// PURPOSE
//  AXI-Stream slave that consumes trace packets produced by the continuous monitoring system
//  and unpacks each beat into named fields.
//  Rebuilds the absolute clock timestamp from per-packet deltas and keeps packet/WFI/error statistics.
//  Sits at the receive end of the trace FIFO; used by on-chip checkers and in simulation benches.
// PARAMETERS
//  NO_OF_EVENTS   39   performance event counters per packet
//  COUNTER_WIDTH  7    width of each event counter field
//  XLEN           64   PC field width
//  CLK_W          64   clock-delta and timestamp width
//  INSTR_W        32   instruction field width
//  AXI_W          512  tdata width; PKT_W=NO_OF_EVENTS*(COUNTER_WIDTH+1)+XLEN+CLK_W+INSTR_W must be <= AXI_W
//  TOTAL_IDX      0    event index accumulated when CMS_DECODER_EVENT_TOTAL_EN is defined
// PORTS
//  clk                  in   1                         clock
//  rst_n                in   1                         reset, asynchronous, active-low
//  clear                in   1                         sync clear of timestamp/statistics
//  S_AXIS_tvalid        in   1                         beat valid
//  S_AXIS_tready        out  1                         beat accept
//  S_AXIS_tdata         in   AXI_W                     packet; bits >= PKT_W ignored
//  S_AXIS_tlast         in   1                         end of burst
//  out_valid            out  1                         decoded packet valid
//  out_ready            in   1                         consumer accept
//  out_counters         out  NO_OF_EVENTS*COUNTER_WIDTH  counter fields, event 0 at LSB
//  out_overflow_map     out  NO_OF_EVENTS              per-event overflow bits
//  out_pc               out  XLEN                      PC field
//  out_delta            out  CLK_W                     clock delta field
//  out_timestamp        out  CLK_W                     running sum of deltas incl. this packet
//  out_instr            out  INSTR_W                   instruction field
//  out_last             out  1                         tlast of this beat
//  out_seq              out  16                        packet sequence number, wraps
//  pkt_count            out  32                        packets accepted since reset/clear, saturates
//  wfi_seen             out  1                         sticky: a packet with instr==32'h10500073 accepted
//  tlast_err            out  1                         sticky: tlast set on a non-WFI instruction
//  event_total          out  32                        see CONFIGURATION
// BEHAVIOUR
//  - Field layout, from LSB: counters | overflow_map | pc | delta | instr.
//  - Input stage: 2-entry skid buffer.
//    - S_AXIS_tready is registered; it equals "buffer not full" at the start of the cycle.
//    - Beat accepted when tvalid & tready.
//  - Output register: out_valid rises in cycle N+1 for a beat accepted in cycle N, if the output is free.
//  - Output stability: while out_valid & ~out_ready, all out_* fields hold stable.
//  - Throughput: one packet per cycle when out_ready is held high.
//  - Ordering: strictly FIFO; no beat is dropped or duplicated under any tvalid/out_ready pattern.
//  - Timestamp: out_timestamp = previous timestamp + delta, computed when a packet moves into the
//    output register. Arithmetic is modulo 2^CLK_W (wraps silently).
//  - Statistics are updated on output-register load:
//    - out_seq +1, wrapping 16'hFFFF->0
//    - pkt_count +1, saturating at 32'hFFFF_FFFF
//    - wfi_seen and tlast_err are set per their definitions
//  - clear (single cycle):
//    - zeroes the timestamp base, out_seq, pkt_count, wfi_seen, tlast_err and event_total
//    - buffered beats are kept
//    - if a load coincides with clear, that packet uses base 0: timestamp=delta, seq=0, pkt_count=1
//  - Reset values:
//    - S_AXIS_tready=0 during reset, 1 from the first clock after deassertion
//    - out_valid=0, all out_* data=0, statistics=0
//  - Reset mid-operation discards the buffered and output packets; no partial beat survives.
// CONFIGURATION
//  CMS_DECODER_EVENT_TOTAL_EN defined:
//    - event_total accumulates counter[TOTAL_IDX] + (overflow_map[TOTAL_IDX] ? 2^COUNTER_WIDTH : 0)
//      on each load, saturating at 32'hFFFF_FFFF
//    - cleared by clear/reset
//  CMS_DECODER_EVENT_TOTAL_EN undefined:
//    - event_total tied to 0; no accumulator logic
// TESTING
//  1. Single beat: pc=0x80000000, delta=5, instr=0x00000013, cnt0=3; out_ready=1
//     -> out_valid 1 cycle later; fields match; timestamp=5; seq=0; pkt_count=1.
//  2. Three beats back-to-back, deltas 5,7,1; out_ready low 4 cycles then high
//     -> tready drops after 2 buffered + 1 output; outputs in order; timestamps 5,12,13; no loss.
//  3. Beat with instr=0x10500073, tlast=1 -> wfi_seen=1, out_last=1, tlast_err=0.
//     Then tlast=1 with instr=0x13 -> tlast_err=1.
//  4. Timestamp base 2^64-2, then delta=5 -> out_timestamp=3.
//     Then clear pulsed together with a delta=9 load -> timestamp=9, seq=0, pkt_count=1.
//  5. rst_n asserted while 2 beats buffered and out_valid=1 -> out_valid=0 immediately;
//     after release the next beat reports seq=0.
//  6. CMS_DECODER_EVENT_TOTAL_EN, TOTAL_IDX=0, COUNTER_WIDTH=7:
//     packets cnt0=10 ovf0=0, then cnt0=4 ovf0=1 -> event_total=10, then 142.

Source files
------------

// File: rtl/cms_trace_pkt_decoder.sv
// Purpose : unpacks CMS trace beats into fields, rebuilds the absolute timestamp, keeps packet statistics.
// Latency : a beat accepted in cycle N is presented on out_* in cycle N+1 when the output register is free.
// Backpressure: 2-entry skid buffer; registered S_AXIS_tready drops only when both buffer entries are occupied.
// Optional: define CMS_DECODER_EVENT_TOTAL_EN to build the event_total accumulator (otherwise tied to 0).
module cms_trace_pkt_decoder #(
    parameter int NO_OF_EVENTS  = 39,
    parameter int COUNTER_WIDTH = 7,
    parameter int XLEN          = 64,
    parameter int CLK_W         = 64,
    parameter int INSTR_W       = 32,
    parameter int AXI_W         = 512,
    parameter int TOTAL_IDX     = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear,
    input  logic                                    S_AXIS_tvalid,
    output logic                                    S_AXIS_tready,
    input  logic [AXI_W-1:0]                        S_AXIS_tdata,
    input  logic                                    S_AXIS_tlast,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [NO_OF_EVENTS*COUNTER_WIDTH-1:0]   out_counters,
    output logic [NO_OF_EVENTS-1:0]                 out_overflow_map,
    output logic [XLEN-1:0]                         out_pc,
    output logic [CLK_W-1:0]                        out_delta,
    output logic [CLK_W-1:0]                        out_timestamp,
    output logic [INSTR_W-1:0]                      out_instr,
    output logic                                    out_last,
    output logic [15:0]                             out_seq,
    output logic [31:0]                             pkt_count,
    output logic                                    wfi_seen,
    output logic                                    tlast_err,
    output logic [31:0]                             event_total
);

    // Packet field layout inside tdata, LSB first: counters | overflow_map | pc | delta | instr.
    localparam int CNT_W   = NO_OF_EVENTS * COUNTER_WIDTH;
    localparam int OVF_LSB = CNT_W;
    localparam int PC_LSB  = OVF_LSB + NO_OF_EVENTS;
    localparam int DLT_LSB = PC_LSB + XLEN;
    localparam int INS_LSB = DLT_LSB + CLK_W;
    localparam int PKT_W   = INS_LSB + INSTR_W;
    // Buffer entry carries the packet plus tlast in the top bit.
    localparam int ENT_W   = PKT_W + 1;

    localparam logic [INSTR_W-1:0] WFI_INSTR = INSTR_W'(32'h1050_0073);

    // Input skid buffer state.
    logic [ENT_W-1:0]           r_buf [2];
    logic                       r_wptr;
    logic                       r_rptr;
    logic [1:0]                 r_cnt;
    logic                       r_tready;

    // Output register and statistics.
    logic                       r_out_vld;
    logic [CNT_W-1:0]           r_out_cnt;
    logic [NO_OF_EVENTS-1:0]    r_out_ovf;
    logic [XLEN-1:0]            r_out_pc;
    logic [CLK_W-1:0]           r_out_delta;
    logic [CLK_W-1:0]           r_out_ts;
    logic [INSTR_W-1:0]         r_out_instr;
    logic                       r_out_last;
    logic [15:0]                r_out_seq;
    logic [15:0]                r_seq_next;
    logic [CLK_W-1:0]           r_ts_base;
    logic [31:0]                r_pkt_count;
    logic                       r_wfi;
    logic                       r_tlast_err;

    logic                       w_accept;
    logic                       w_out_free;
    logic                       w_buf_empty;
    logic                       w_load;
    logic                       w_pop;
    logic                       w_push;
    logic [1:0]                 w_cnt_next;
    logic [ENT_W-1:0]           w_in_ent;
    logic [ENT_W-1:0]           w_ld_ent;

    logic [CNT_W-1:0]           w_ld_cnt;
    logic [NO_OF_EVENTS-1:0]    w_ld_ovf;
    logic [XLEN-1:0]            w_ld_pc;
    logic [CLK_W-1:0]           w_ld_delta;
    logic [INSTR_W-1:0]         w_ld_instr;
    logic                       w_ld_last;
    logic                       w_ld_is_wfi;

    logic [CLK_W-1:0]           w_ts_base;
    logic [CLK_W-1:0]           w_ts_new;
    logic [15:0]                w_seq_base;
    logic [31:0]                w_pcnt_base;
    logic [31:0]                w_pcnt_new;
    logic                       w_wfi_base;
    logic                       w_terr_base;

    // Bits of tdata above the packet are deliberately ignored.
    generate
        if (PKT_W < AXI_W) begin : g_pad
            logic w_unused_tdata;
            assign w_unused_tdata = ^S_AXIS_tdata[AXI_W-1:PKT_W];
        end
    endgenerate

    assign w_in_ent    = {S_AXIS_tlast, S_AXIS_tdata[PKT_W-1:0]};
    assign w_accept    = S_AXIS_tvalid & r_tready;
    assign w_out_free  = ~r_out_vld | out_ready;
    assign w_buf_empty = (r_cnt == 2'd0);

    // Older buffered beats always go first; an incoming beat bypasses the
    // buffer only when the buffer is empty, which keeps strict FIFO order.
    assign w_pop       = w_out_free & ~w_buf_empty;
    assign w_load      = w_out_free & (~w_buf_empty | w_accept);
    assign w_push      = w_accept & ~(w_out_free & w_buf_empty);
    assign w_cnt_next  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    assign w_ld_ent    = w_buf_empty ? w_in_ent : r_buf[r_rptr];

    assign w_ld_cnt    = w_ld_ent[CNT_W-1:0];
    assign w_ld_ovf    = w_ld_ent[OVF_LSB +: NO_OF_EVENTS];
    assign w_ld_pc     = w_ld_ent[PC_LSB +: XLEN];
    assign w_ld_delta  = w_ld_ent[DLT_LSB +: CLK_W];
    assign w_ld_instr  = w_ld_ent[INS_LSB +: INSTR_W];
    assign w_ld_last   = w_ld_ent[PKT_W];
    assign w_ld_is_wfi = (w_ld_instr == WFI_INSTR);

    // A clear in the same cycle as a load makes the loaded packet start from zeroed bases.
    assign w_ts_base   = clear ? '0 : r_ts_base;
    assign w_ts_new    = w_ts_base + w_ld_delta;
    assign w_seq_base  = clear ? 16'd0 : r_seq_next;
    assign w_pcnt_base = clear ? 32'd0 : r_pkt_count;
    assign w_pcnt_new  = (w_pcnt_base == 32'hFFFF_FFFF) ? w_pcnt_base : w_pcnt_base + 32'd1;
    assign w_wfi_base  = clear ? 1'b0 : r_wfi;
    assign w_terr_base = clear ? 1'b0 : r_tlast_err;

    // Buffer storage: payload only, validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wptr] <= w_in_ent;
        end
    end

    // Buffer pointers, occupancy and the registered ready (not full for the next cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
            r_tready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt    <= w_cnt_next;
            r_tready <= (w_cnt_next != 2'd2);
        end
    end

    // Output register: loads the next packet whenever it is empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_cnt   <= '0;
            r_out_ovf   <= '0;
            r_out_pc    <= '0;
            r_out_delta <= '0;
            r_out_ts    <= '0;
            r_out_instr <= '0;
            r_out_last  <= 1'b0;
            r_out_seq   <= 16'd0;
        end else begin
            if (w_out_free) begin
                r_out_vld <= w_load;
            end
            if (w_load) begin
                r_out_cnt   <= w_ld_cnt;
                r_out_ovf   <= w_ld_ovf;
                r_out_pc    <= w_ld_pc;
                r_out_delta <= w_ld_delta;
                r_out_ts    <= w_ts_new;
                r_out_instr <= w_ld_instr;
                r_out_last  <= w_ld_last;
                r_out_seq   <= w_seq_base;
            end
        end
    end

    // Running timestamp base and statistics; clear zeroes them without disturbing a held output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_base   <= '0;
            r_seq_next  <= 16'd0;
            r_pkt_count <= 32'd0;
            r_wfi       <= 1'b0;
            r_tlast_err <= 1'b0;
        end else if (w_load) begin
            r_ts_base   <= w_ts_new;
            r_seq_next  <= w_seq_base + 16'd1;
            r_pkt_count <= w_pcnt_new;
            r_wfi       <= w_wfi_base | w_ld_is_wfi;
            r_tlast_err <= w_terr_base | (w_ld_last & ~w_ld_is_wfi);
        end else if (clear) begin
            r_ts_base   <= '0;
            r_seq_next  <= 16'd0;
            r_pkt_count <= 32'd0;
            r_wfi       <= 1'b0;
            r_tlast_err <= 1'b0;
        end
    end

`ifdef CMS_DECODER_EVENT_TOTAL_EN
    logic [31:0]            r_evt_total;
    logic [31:0]            w_evt_base;
    logic [COUNTER_WIDTH:0] w_evt_add;
    logic [32:0]            w_evt_sum;
    logic [31:0]            w_evt_new;

    // Overflow bit sits just above the counter MSB, so concatenation gives cnt + ovf*2^COUNTER_WIDTH.
    assign w_evt_add  = {w_ld_ovf[TOTAL_IDX], w_ld_cnt[TOTAL_IDX*COUNTER_WIDTH +: COUNTER_WIDTH]};
    assign w_evt_base = clear ? 32'd0 : r_evt_total;
    assign w_evt_sum  = {1'b0, w_evt_base} + 33'(w_evt_add);
    assign w_evt_new  = w_evt_sum[32] ? 32'hFFFF_FFFF : w_evt_sum[31:0];

    // Saturating accumulator of the selected event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_total <= 32'd0;
        end else if (w_load) begin
            r_evt_total <= w_evt_new;
        end else if (clear) begin
            r_evt_total <= 32'd0;
        end
    end

    assign event_total = r_evt_total;
`else
    assign event_total = 32'd0;
`endif

    assign S_AXIS_tready    = r_tready;
    assign out_valid        = r_out_vld;
    assign out_counters     = r_out_cnt;
    assign out_overflow_map = r_out_ovf;
    assign out_pc           = r_out_pc;
    assign out_delta        = r_out_delta;
    assign out_timestamp    = r_out_ts;
    assign out_instr        = r_out_instr;
    assign out_last         = r_out_last;
    assign out_seq          = r_out_seq;
    assign pkt_count        = r_pkt_count;
    assign wfi_seen         = r_wfi;
    assign tlast_err        = r_tlast_err;

endmodule

// File: tb/tb_cms_trace_pkt_decoder.sv
// Directed bench for cms_trace_pkt_decoder with default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_cms_trace_pkt_decoder;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         S_AXIS_tvalid;
    logic         S_AXIS_tready;
    logic [511:0] S_AXIS_tdata;
    logic         S_AXIS_tlast;
    logic         out_valid;
    logic         out_ready;
    logic [272:0] out_counters;
    logic [38:0]  out_overflow_map;
    logic [63:0]  out_pc;
    logic [63:0]  out_delta;
    logic [63:0]  out_timestamp;
    logic [31:0]  out_instr;
    logic         out_last;
    logic [15:0]  out_seq;
    logic [31:0]  pkt_count;
    logic         wfi_seen;
    logic         tlast_err;
    logic [31:0]  event_total;

    int total = 0;
    int bad   = 0;

    cms_trace_pkt_decoder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .S_AXIS_tvalid    (S_AXIS_tvalid),
        .S_AXIS_tready    (S_AXIS_tready),
        .S_AXIS_tdata     (S_AXIS_tdata),
        .S_AXIS_tlast     (S_AXIS_tlast),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_counters     (out_counters),
        .out_overflow_map (out_overflow_map),
        .out_pc           (out_pc),
        .out_delta        (out_delta),
        .out_timestamp    (out_timestamp),
        .out_instr        (out_instr),
        .out_last         (out_last),
        .out_seq          (out_seq),
        .pkt_count        (pkt_count),
        .wfi_seen         (wfi_seen),
        .tlast_err        (tlast_err),
        .event_total      (event_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    // Packet builder: event 0 counter/overflow, event 38 counter fixed at 7'h5A,
    // and junk above bit 471 which the decoder must ignore.
    function automatic logic [511:0] mk(input logic [6:0] c0, input logic o0,
                                        input logic [63:0] pc, input logic [63:0] dl,
                                        input logic [31:0] ins);
        logic [511:0] d;
        d            = '0;
        d[6:0]       = c0;
        d[272:266]   = 7'h5A;
        d[273]       = o0;
        d[312 +: 64] = pc;
        d[376 +: 64] = dl;
        d[440 +: 32] = ins;
        d[511:472]   = 40'hDE_ADBE_EF99;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [511:0] d, input logic last);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = d;
        S_AXIS_tlast  = last;
    endtask

    task automatic idle();
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = '0;
        S_AXIS_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; idle();
        tick(); tick();
        total++; if (S_AXIS_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%0b need=0", S_AXIS_tready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b need=0", out_valid); end
        total++; if (out_timestamp !== 64'd0 || out_pc !== 64'd0 || out_counters !== '0) begin bad++; $display("FAIL reset_data ts=%0h pc=%0h need 0", out_timestamp, out_pc); end
        total++; if (pkt_count !== 32'd0 || out_seq !== 16'd0 || wfi_seen !== 1'b0 || tlast_err !== 1'b0 || event_total !== 32'd0) begin bad++; $display("FAIL reset_stats cnt=%0d seq=%0d need 0", pkt_count, out_seq); end
        rst_n = 1'b1;
        tick();
        total++; if (S_AXIS_tready !== 1'b1) begin bad++; $display("FAIL tready_after_reset got=%0b need=1", S_AXIS_tready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(mk(7'd3, 1'b0, 64'h8000_0000, 64'd5, 32'h0000_0013), 1'b0);
        tick();
        idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b need=1", out_valid); end
        total++; if (out_pc !== 64'h8000_0000 || out_delta !== 64'd5 || out_instr !== 32'h13) begin bad++; $display("FAIL single_fields pc=%0h dl=%0d ins=%0h need 80000000/5/13", out_pc, out_delta, out_instr); end
        total++; if (out_counters[6:0] !== 7'd3 || out_counters[272:266] !== 7'h5A || out_counters[265:7] !== '0) begin bad++; $display("FAIL single_counters c0=%0d c38=%0h need 3/5a", out_counters[6:0], out_counters[272:266]); end
        total++; if (out_overflow_map !== 39'd0 || out_last !== 1'b0) begin bad++; $display("FAIL single_ovf_last ovf=%0h last=%0b need 0/0", out_overflow_map, out_last); end
        total++; if (out_timestamp !== 64'd5 || out_seq !== 16'd0 || pkt_count !== 32'd1) begin bad++; $display("FAIL single_stats ts=%0d seq=%0d cnt=%0d need 5/0/1", out_timestamp, out_seq, pkt_count); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b need=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1; tick(); clear = 1'b0;
        out_ready = 1'b0;
        drive(mk(7'd1, 1'b0, 64'hA0, 64'd5, 32'h13), 1'b0);
        tick();
        total++; if (S_AXIS_tready !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first rdy=%0b vld=%0b need 1/1", S_AXIS_tready, out_valid); end
        drive(mk(7'd2, 1'b0, 64'hB0, 64'd7, 32'h13), 1'b0);
        tick();
        total++; if (S_AXIS_tready !== 1'b1) begin bad++; $display("FAIL b2b_one_buffered rdy=%0b need=1", S_AXIS_tready); end
        drive(mk(7'd3, 1'b0, 64'hC0, 64'd1, 32'h13), 1'b0);
        tick();
        idle();
        total++; if (S_AXIS_tready !== 1'b0) begin bad++; $display("FAIL b2b_full rdy=%0b need=0", S_AXIS_tready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 64'hA0 || out_timestamp !== 64'd5 || out_seq !== 16'd0 || out_counters[6:0] !== 7'd1) begin bad++; $display("FAIL b2b_hold pc=%0h ts=%0d seq=%0d need a0/5/0", out_pc, out_timestamp, out_seq); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 64'hB0 || out_timestamp !== 64'd12 || out_seq !== 16'd1 || pkt_count !== 32'd2) begin bad++; $display("FAIL b2b_second pc=%0h ts=%0d seq=%0d cnt=%0d need b0/12/1/2", out_pc, out_timestamp, out_seq, pkt_count); end
        total++; if (S_AXIS_tready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back rdy=%0b need=1", S_AXIS_tready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 64'hC0 || out_timestamp !== 64'd13 || out_seq !== 16'd2 || pkt_count !== 32'd3) begin bad++; $display("FAIL b2b_third pc=%0h ts=%0d seq=%0d cnt=%0d need c0/13/2/3", out_pc, out_timestamp, out_seq, pkt_count); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup vld=%0b need=0", out_valid); end
    endtask

    task automatic test_wfi();
        out_ready = 1'b1;
        drive(mk(7'd0, 1'b0, 64'h100, 64'd2, 32'h1050_0073), 1'b1);
        tick();
        idle();
        total++; if (out_valid !== 1'b1 || wfi_seen !== 1'b1 || out_last !== 1'b1 || tlast_err !== 1'b0) begin bad++; $display("FAIL wfi_tlast vld=%0b wfi=%0b last=%0b terr=%0b need 1/1/1/0", out_valid, wfi_seen, out_last, tlast_err); end
        total++; if (out_timestamp !== 64'd15) begin bad++; $display("FAIL wfi_ts got=%0d need=15", out_timestamp); end
        drive(mk(7'd0, 1'b0, 64'h104, 64'd0, 32'h13), 1'b1);
        tick();
        idle();
        total++; if (tlast_err !== 1'b1 || out_last !== 1'b1 || wfi_seen !== 1'b1) begin bad++; $display("FAIL tlast_err terr=%0b last=%0b wfi=%0b need 1/1/1", tlast_err, out_last, wfi_seen); end
        tick();
    endtask

    task automatic test_wrap_and_clear();
        out_ready = 1'b1;
        clear = 1'b1;
        drive(mk(7'd0, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 32'h13), 1'b0);
        tick();
        clear = 1'b0;
        total++; if (out_timestamp !== 64'hFFFF_FFFF_FFFF_FFFE || out_seq !== 16'd0 || pkt_count !== 32'd1) begin bad++; $display("FAIL wrap_base ts=%0h seq=%0d cnt=%0d need fffffffffffffffe/0/1", out_timestamp, out_seq, pkt_count); end
        total++; if (wfi_seen !== 1'b0 || tlast_err !== 1'b0) begin bad++; $display("FAIL clear_sticky wfi=%0b terr=%0b need 0/0", wfi_seen, tlast_err); end
        drive(mk(7'd0, 1'b0, 64'h204, 64'd5, 32'h13), 1'b0);
        tick();
        total++; if (out_timestamp !== 64'd3 || out_seq !== 16'd1 || pkt_count !== 32'd2) begin bad++; $display("FAIL wrap_sum ts=%0d seq=%0d cnt=%0d need 3/1/2", out_timestamp, out_seq, pkt_count); end
        clear = 1'b1;
        drive(mk(7'd0, 1'b0, 64'h208, 64'd9, 32'h13), 1'b0);
        tick();
        clear = 1'b0;
        idle();
        total++; if (out_timestamp !== 64'd9 || out_seq !== 16'd0 || pkt_count !== 32'd1) begin bad++; $display("FAIL clear_with_load ts=%0d seq=%0d cnt=%0d need 9/0/1", out_timestamp, out_seq, pkt_count); end
        tick();
    endtask

    task automatic test_event_total();
        out_ready = 1'b1;
        clear = 1'b1;
        drive(mk(7'd10, 1'b0, 64'h300, 64'd1, 32'h13), 1'b0);
        tick();
        clear = 1'b0;
`ifdef CMS_DECODER_EVENT_TOTAL_EN
        total++; if (event_total !== 32'd10) begin bad++; $display("FAIL evt_first got=%0d need=10", event_total); end
        drive(mk(7'd4, 1'b1, 64'h304, 64'd1, 32'h13), 1'b0);
        tick();
        total++; if (event_total !== 32'd142) begin bad++; $display("FAIL evt_overflow got=%0d need=142", event_total); end
`else
        total++; if (event_total !== 32'd0) begin bad++; $display("FAIL evt_tied got=%0d need=0", event_total); end
        drive(mk(7'd4, 1'b1, 64'h304, 64'd1, 32'h13), 1'b0);
        tick();
        total++; if (out_overflow_map[0] !== 1'b1 || out_counters[6:0] !== 7'd4) begin bad++; $display("FAIL evt_fields ovf0=%0b c0=%0d need 1/4", out_overflow_map[0], out_counters[6:0]); end
`endif
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(mk(7'd0, 1'b0, 64'h400, 64'd3, 32'h13), 1'b0);
        tick();
        drive(mk(7'd0, 1'b0, 64'h404, 64'd3, 32'h13), 1'b0);
        tick();
        drive(mk(7'd0, 1'b0, 64'h408, 64'd3, 32'h13), 1'b0);
        tick();
        idle();
        total++; if (out_valid !== 1'b1 || S_AXIS_tready !== 1'b0) begin bad++; $display("FAIL rstmid_setup vld=%0b rdy=%0b need 1/0", out_valid, S_AXIS_tready); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || S_AXIS_tready !== 1'b0 || pkt_count !== 32'd0) begin bad++; $display("FAIL rstmid_async vld=%0b rdy=%0b cnt=%0d need 0/0/0", out_valid, S_AXIS_tready, pkt_count); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || S_AXIS_tready !== 1'b1) begin bad++; $display("FAIL rstmid_flushed vld=%0b rdy=%0b need 0/1", out_valid, S_AXIS_tready); end
        drive(mk(7'd0, 1'b0, 64'h500, 64'd4, 32'h13), 1'b0);
        tick();
        idle();
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h500 || out_seq !== 16'd0 || out_timestamp !== 64'd4 || pkt_count !== 32'd1) begin bad++; $display("FAIL rstmid_next pc=%0h seq=%0d ts=%0d cnt=%0d need 500/0/4/1", out_pc, out_seq, out_timestamp, pkt_count); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_ghost vld=%0b need=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wfi();
        test_wrap_and_clear();
        test_event_total();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
